// File: rtl/spi_tx_frame_feeder.sv
// Byte FIFO plus chip-select/strobe sequencer feeding a byte-level SPI transmitter.
// Optional busy-rise watchdog enabled by defining SPI_FEEDER_WDOG_EN.
module spi_tx_frame_feeder #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CS_SETUP    = 100,
    parameter int unsigned CS_HOLD     = 100,
    parameter int unsigned BYTE_GAP    = 0,
    parameter int unsigned CS_IDLE     = 50,
    parameter int unsigned WDOG_CYCLES = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [7:0]                 s_data_i,
    input  logic                       s_last_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    output logic                       spi_tx_en_o,
    output logic [7:0]                 spi_tx_data_o,
    input  logic                       spi_busy_i,
    output logic                       spi_cs_n_o,
    output logic                       frame_done_o,
    output logic [$clog2(DEPTH):0]     fifo_level_o,
    output logic                       err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [15:0] SetupLen = 16'((CS_SETUP > 0) ? CS_SETUP : 1);
    localparam logic [15:0] HoldLen  = 16'((CS_HOLD > 0) ? CS_HOLD : 1);
    localparam logic [15:0] IdleLen  = 16'((CS_IDLE > 0) ? CS_IDLE : 1);
    localparam logic [15:0] GapLen   = 16'(BYTE_GAP);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CS_SETUP > 65535 || CS_HOLD > 65535 ||
        BYTE_GAP > 65535 || CS_IDLE > 65535 || WDOG_CYCLES > 65535) begin : g_bad_params
        $error("spi_tx_frame_feeder: illegal parameter value");
    end

    typedef enum logic [2:0] {
        StIdle, StSetup, StLoad, StWaitHi, StWaitLo, StGap, StHold, StIdleGap
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       timer_q, timer_d, timer_inc;
    logic              last_q, last_d;
    logic              flush_q, flush_d;
    logic              err_q, err_d;
    logic [8:0]        mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              ready_q;
    logic              cs_n_q, cs_n_d;
    logic              tx_en_q, tx_en_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              frame_done_q;
    logic              push, pop, flush_pop, empty, avail;
    logic [8:0]        head;

    assign push      = s_valid_i & ready_q;
    assign pop       = tx_en_q | flush_pop;
    assign empty     = (level_q == '0);
    // A byte arriving this cycle is enough to resume an open frame.
    assign avail     = ~empty | push;
    assign head      = mem_q[rptr_q];
    assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_inc;
        last_d    = last_q;
        flush_d   = flush_q;
        err_d     = err_q;
        flush_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (!empty && !spi_busy_i && !flush_q) state_d = StSetup;
            end
            StSetup: begin
                if (timer_q >= SetupLen - 16'd1) begin
                    state_d = StLoad;
                    timer_d = '0;
                end
            end
            StLoad: begin
                last_d  = head[8];
                state_d = StWaitHi;
                timer_d = '0;
            end
            StWaitHi: begin
                if (spi_busy_i) begin
                    state_d = StWaitLo;
                end
`ifdef SPI_FEEDER_WDOG_EN
                else if (timer_q >= 16'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0)) begin
                    err_d   = 1'b1;
                    flush_d = ~last_q;
                    state_d = StHold;
                    timer_d = '0;
                end
`endif
            end
            StWaitLo: begin
                if (!spi_busy_i) begin
                    timer_d = '0;
                    if (last_q)                        state_d = StHold;
                    else if (GapLen == 16'd0 && avail) state_d = StLoad;
                    else                               state_d = StGap;
                end
            end
            StGap: begin
                if ((GapLen == 16'd0 || timer_q >= GapLen - 16'd1) && avail) begin
                    state_d = StLoad;
                    timer_d = '0;
                end
            end
            StHold: begin
                if (timer_q >= HoldLen - 16'd1) begin
                    state_d = StIdleGap;
                    timer_d = '0;
                end
            end
            StIdleGap: begin
                if (timer_q >= IdleLen - 16'd1) begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef SPI_FEEDER_WDOG_EN
        // Drain the rest of an aborted frame, up to and including its last byte.
        if (flush_q && !empty &&
            (state_q == StHold || state_q == StIdleGap || state_q == StIdle)) begin
            flush_pop = 1'b1;
            if (head[8]) flush_d = 1'b0;
        end
`endif
    end

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (!push && pop) level_d = level_q - LW'(1);
        // Outputs follow the state register by one edge.
        cs_n_d    = (state_q == StIdle) || (state_q == StIdleGap);
        tx_en_d   = (state_q == StLoad);
        tx_data_d = tx_en_d ? head[7:0] : tx_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            last_q       <= 1'b0;
            flush_q      <= 1'b0;
            err_q        <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            ready_q      <= 1'b1;
            cs_n_q       <= 1'b1;
            tx_en_q      <= 1'b0;
            tx_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            last_q       <= last_d;
            flush_q      <= flush_d;
            err_q        <= err_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            level_q      <= level_d;
            ready_q      <= (level_d != LW'(DEPTH));
            cs_n_q       <= cs_n_d;
            tx_en_q      <= tx_en_d;
            tx_data_q    <= tx_data_d;
            frame_done_q <= cs_n_d & ~cs_n_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) mem_q[wptr_q] <= {s_last_i, s_data_i};
    end

    assign s_ready_o     = ready_q;
    assign spi_tx_en_o   = tx_en_q;
    assign spi_tx_data_o = tx_data_q;
    assign spi_cs_n_o    = cs_n_q;
    assign frame_done_o  = frame_done_q;
    assign fifo_level_o  = level_q;
    assign err_o         = err_q;

endmodule
